branch_issue_queue: RTL and testbench

- Reservation station feeding the branch unit. Acts as the initiator side of the branch unit's issue interface (issue_en, issue_entry, rs1_data, rs2_data, ready).
- Accepts dispatched branch/JALR entries and tracks operand readiness via writeback wakeup.
- Selects the oldest fully-ready entry and issues it with operand data read from the physical register file.
- Sits between rename/dispatch and branch_unit; cleared by flush.

---
 rtl/ooo_types.sv | 24 ++
 rtl/iq_wakeup_cmp.sv | 26 ++
 rtl/branch_issue_queue.sv | 184 ++++++++++++++++++
 tb/tb_branch_issue_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_types.sv
// Shared out-of-order core types: physical register/ROB widths, branch op
// encodings and the reservation-station entry layout.
package ooo_types;

    localparam int PHYS_REG_BITS = 7;
    localparam int ROB_BITS      = 4;

    localparam logic [1:0] ALU_OP_JALR   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] prs1;
        logic [PHYS_REG_BITS-1:0] prs2;
        logic                     rs1_rdy;
        logic                     rs2_rdy;
        logic [ROB_BITS-1:0]      rob_tag;
        logic [31:0]              pc;
        logic [31:0]              immediate;
        logic [1:0]               alu_op;
        logic [PHYS_REG_BITS-1:0] prd;
        logic                     reg_write;
    } rs_entry_t;

endpackage

// File: rtl/iq_wakeup_cmp.sv
// Single source-tag comparator: flags a hit when any writeback port
// broadcasts the physical register this operand is waiting on.
module iq_wakeup_cmp
    import ooo_types::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic [PHYS_REG_BITS-1:0]             tag_i,
    input  logic [NUM_WB-1:0]                    wb_valid,
    input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] wb_prd,
    output logic                                 hit
);

    // OR-reduce the per-port tag matches.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_prd[k] == tag_i)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/branch_issue_queue.sv
// Collapsing reservation station for the branch unit. Slot 0 is the oldest
// entry; the oldest fully-ready entry is offered to the branch unit each
// cycle with operands read combinationally from the physical register file.
module branch_issue_queue
    import ooo_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int NUM_WB = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dispatch_valid,
    input  rs_entry_t                            dispatch_entry,
    output logic                                 dispatch_ready,
    input  logic [NUM_WB-1:0]                    wb_valid,
    input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] wb_prd,
    output logic [PHYS_REG_BITS-1:0]             prf_raddr1,
    output logic [PHYS_REG_BITS-1:0]             prf_raddr2,
    input  logic [31:0]                          prf_rdata1,
    input  logic [31:0]                          prf_rdata2,
    output logic                                 issue_en,
    output rs_entry_t                            issue_entry,
    output logic [31:0]                          rs1_data,
    output logic [31:0]                          rs2_data,
    input  logic                                 ready,
    input  logic                                 flush,
    output logic [$clog2(DEPTH):0]               occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] r1_q, r1_d;
    logic [DEPTH-1:0] r2_q, r2_d;
    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             found_s;
    logic [IDX_W-1:0] sel_s;
    logic             do_issue_s;
    logic             do_disp_s;
    logic [OCC_W-1:0] tail_s;

    // Slot contents after collapse and append, before wakeup. One extra
    // empty slot on top lets the last slot shift in "nothing".
    logic [DEPTH:0]   ext_valid_s, ext_r1_s, ext_r2_s;
    rs_entry_t        ext_ent_s [DEPTH+1];
    logic [DEPTH-1:0] sh_valid_s, sh_r1_s, sh_r2_s;
    rs_entry_t        sh_ent_s [DEPTH];
    logic [DEPTH-1:0] hit1_s, hit2_s;

    // Oldest-ready select: scan from the top so the lowest index wins.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && r1_q[i] && r2_q[i]) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Issue/dispatch handshakes; flush blocks both without waiting a cycle.
    always_comb begin
        issue_en       = found_s && !flush;
        dispatch_ready = (occ_q < OCC_W'(DEPTH)) && !flush;
        do_issue_s     = issue_en && ready;
        do_disp_s      = dispatch_valid && dispatch_ready;
        tail_s         = occ_q - OCC_W'(do_issue_s);
        occupancy      = occ_q;
    end

    // Issue-side datapath; quiet zeros whenever nothing is issued.
    always_comb begin
        if (issue_en) begin
            issue_entry = ent_q[sel_s];
            prf_raddr1  = ent_q[sel_s].prs1;
            prf_raddr2  = ent_q[sel_s].prs2;
            rs1_data    = prf_rdata1;
            rs2_data    = prf_rdata2;
        end else begin
            issue_entry = '0;
            prf_raddr1  = '0;
            prf_raddr2  = '0;
            rs1_data    = 32'd0;
            rs2_data    = 32'd0;
        end
    end

    // Collapse above the issued slot and append the dispatched entry at the
    // post-collapse tail.
    always_comb begin
        ext_valid_s = {1'b0, valid_q};
        ext_r1_s    = {1'b0, r1_q};
        ext_r2_s    = {1'b0, r2_q};
        for (int j = 0; j < DEPTH; j++) begin
            ext_ent_s[j] = ent_q[j];
        end
        ext_ent_s[DEPTH] = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (do_issue_s && (j >= int'(sel_s))) begin
                sh_valid_s[j] = ext_valid_s[j+1];
                sh_r1_s[j]    = ext_r1_s[j+1];
                sh_r2_s[j]    = ext_r2_s[j+1];
                sh_ent_s[j]   = ext_ent_s[j+1];
            end else begin
                sh_valid_s[j] = ext_valid_s[j];
                sh_r1_s[j]    = ext_r1_s[j];
                sh_r2_s[j]    = ext_r2_s[j];
                sh_ent_s[j]   = ext_ent_s[j];
            end
            if (do_disp_s && (OCC_W'(j) == tail_s)) begin
                sh_valid_s[j] = 1'b1;
                sh_r1_s[j]    = dispatch_entry.rs1_rdy;
                sh_r2_s[j]    = dispatch_entry.rs2_rdy;
                sh_ent_s[j]   = dispatch_entry;
            end else begin
                sh_valid_s[j] = sh_valid_s[j];
            end
        end
    end

    // Wakeup compares run on the shifted slots so a same-cycle dispatch
    // still sees this cycle's writebacks.
    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_wakeup_cmp #(.NUM_WB(NUM_WB)) u_cmp1 (
            .tag_i    (sh_ent_s[g].prs1),
            .wb_valid (wb_valid),
            .wb_prd   (wb_prd),
            .hit      (hit1_s[g])
        );
        iq_wakeup_cmp #(.NUM_WB(NUM_WB)) u_cmp2 (
            .tag_i    (sh_ent_s[g].prs2),
            .wb_valid (wb_valid),
            .wb_prd   (wb_prd),
            .hit      (hit2_s[g])
        );
    end

    // Next state: flush drops everything, otherwise apply all events.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j] = sh_ent_s[j];
        end
        if (flush) begin
            valid_d = '0;
            r1_d    = '0;
            r2_d    = '0;
            occ_d   = '0;
        end else begin
            valid_d = sh_valid_s;
            r1_d    = sh_r1_s | hit1_s;
            r2_d    = sh_r2_s | hit2_s;
            occ_d   = tail_s + OCC_W'(do_disp_s);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            occ_q   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            occ_q   <= occ_d;
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= ent_d[j];
            end
        end
    end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed self-checking bench for branch_issue_queue (DEPTH=4, NUM_WB=2).
module tb_branch_issue_queue;
    import ooo_types::*;

    localparam int DEPTH  = 4;
    localparam int NUM_WB = 2;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 dispatch_valid;
    rs_entry_t                            dispatch_entry;
    logic                                 dispatch_ready;
    logic [NUM_WB-1:0]                    wb_valid;
    logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] wb_prd;
    logic [PHYS_REG_BITS-1:0]             prf_raddr1, prf_raddr2;
    logic [31:0]                          prf_rdata1, prf_rdata2;
    logic                                 issue_en;
    rs_entry_t                            issue_entry;
    logic [31:0]                          rs1_data, rs2_data;
    logic                                 ready;
    logic                                 flush;
    logic [2:0]                           occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_entry (dispatch_entry),
        .dispatch_ready (dispatch_ready),
        .wb_valid       (wb_valid),
        .wb_prd         (wb_prd),
        .prf_raddr1     (prf_raddr1),
        .prf_raddr2     (prf_raddr2),
        .prf_rdata1     (prf_rdata1),
        .prf_rdata2     (prf_rdata2),
        .issue_en       (issue_en),
        .issue_entry    (issue_entry),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .ready          (ready),
        .flush          (flush),
        .occupancy      (occupancy)
    );

    function automatic rs_entry_t mk(input logic [3:0] tag, input logic [6:0] p1,
                                     input logic [6:0] p2, input logic r1, input logic r2);
        rs_entry_t e;
        e           = '0;
        e.rob_tag   = tag;
        e.prs1      = p1;
        e.prs2      = p2;
        e.rs1_rdy   = r1;
        e.rs2_rdy   = r2;
        e.pc        = 32'h0000_1000 + {26'd0, tag, 2'b00};
        e.immediate = 32'h0000_0010;
        e.alu_op    = ALU_OP_BRANCH;
        e.prd       = 7'd0;
        e.reg_write = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue(input string tag, input rs_entry_t exp);
        check({tag, "_en"}, 128'(issue_en), 128'(1'b1));
        check({tag, "_entry"}, 128'(issue_entry), 128'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Time bound: never let the bench hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_entry = '0;
        wb_valid       = '0;
        wb_prd         = '0;
        prf_rdata1     = 32'hA5A5_0001;
        prf_rdata2     = 32'h5A5A_0002;
        ready          = 1'b1;
        flush          = 1'b0;

        // Reset for two edges.
        tick();
        tick();
        #1;
        check("rst_issue_en", 128'(issue_en), 128'(1'b0));
        check("rst_disp_rdy", 128'(dispatch_ready), 128'(1'b1));
        check("rst_occ", 128'(occupancy), 128'(3'd0));
        rst = 1'b1;

        // Fully-ready BEQ issues the cycle after dispatch.
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd0, 7'd5, 7'd6, 1'b1, 1'b1);
        tick();
        dispatch_valid = 1'b0;
        #1;
        check_issue("t1", mk(4'd0, 7'd5, 7'd6, 1'b1, 1'b1));
        check("t1_raddr1", 128'(prf_raddr1), 128'(7'd5));
        check("t1_raddr2", 128'(prf_raddr2), 128'(7'd6));
        check("t1_rs1", 128'(rs1_data), 128'(32'hA5A5_0001));
        check("t1_rs2", 128'(rs2_data), 128'(32'h5A5A_0002));
        check("t1_occ1", 128'(occupancy), 128'(3'd1));
        tick();
        check("t1_occ0", 128'(occupancy), 128'(3'd0));
        check("t1_idle", 128'(issue_en), 128'(1'b0));

        // Younger ready entry overtakes a waiting older one; wakeup releases it.
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd1, 7'd9, 7'd3, 1'b0, 1'b1);
        tick();
        dispatch_entry = mk(4'd2, 7'd10, 7'd11, 1'b1, 1'b1);
        #1;
        check("t2_wait", 128'(issue_en), 128'(1'b0));
        tick();
        dispatch_valid = 1'b0;
        #1;
        check_issue("t2_tag2", mk(4'd2, 7'd10, 7'd11, 1'b1, 1'b1));
        check("t2_occ2", 128'(occupancy), 128'(3'd2));
        tick();
        wb_valid  = 2'b01;
        wb_prd[0] = 7'd9;
        #1;
        check("t2_occ1", 128'(occupancy), 128'(3'd1));
        check("t2_not_yet", 128'(issue_en), 128'(1'b0));
        tick();
        wb_valid = 2'b00;
        #1;
        check_issue("t2_tag1", mk(4'd1, 7'd9, 7'd3, 1'b0, 1'b1));
        check("t2_raddr1", 128'(prf_raddr1), 128'(7'd9));
        tick();
        check("t2_empty", 128'(occupancy), 128'(3'd0));

        // Fill to full with ready low, then drain in age order with an
        // append landing during the drain.
        ready          = 1'b0;
        dispatch_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            dispatch_entry = mk(4'(t), 7'(20 + t), 7'(40 + t), 1'b1, 1'b1);
            tick();
        end
        dispatch_entry = mk(4'd7, 7'd1, 7'd2, 1'b1, 1'b1);
        #1;
        check("t3_full_occ", 128'(occupancy), 128'(3'd4));
        check("t3_full_rdy", 128'(dispatch_ready), 128'(1'b0));
        check_issue("t3_hold", mk(4'd0, 7'd20, 7'd40, 1'b1, 1'b1));
        tick();
        check("t3_full_stall", 128'(occupancy), 128'(3'd4));
        check_issue("t3_stable", mk(4'd0, 7'd20, 7'd40, 1'b1, 1'b1));
        dispatch_valid = 1'b0;
        ready          = 1'b1;
        #1;
        check("t3_full_rdy2", 128'(dispatch_ready), 128'(1'b0));
        tick();
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd5, 7'd1, 7'd2, 1'b1, 1'b1);
        #1;
        check("t3_rdy_after", 128'(dispatch_ready), 128'(1'b1));
        check("t3_occ3", 128'(occupancy), 128'(3'd3));
        check_issue("t3_tag1", mk(4'd1, 7'd21, 7'd41, 1'b1, 1'b1));
        tick();
        dispatch_valid = 1'b0;
        #1;
        check("t3_occ_same", 128'(occupancy), 128'(3'd3));
        check_issue("t3_tag2", mk(4'd2, 7'd22, 7'd42, 1'b1, 1'b1));
        tick();
        check_issue("t3_tag3", mk(4'd3, 7'd23, 7'd43, 1'b1, 1'b1));
        tick();
        check_issue("t3_tag5", mk(4'd5, 7'd1, 7'd2, 1'b1, 1'b1));
        tick();
        check("t3_drained", 128'(occupancy), 128'(3'd0));

        // Wakeup in the dispatch cycle is not lost; a wrong tag wakes nothing.
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd6, 7'd4, 7'd12, 1'b1, 1'b0);
        wb_valid       = 2'b10;
        wb_prd[0]      = 7'd12;
        wb_prd[1]      = 7'd12;
        tick();
        dispatch_valid = 1'b0;
        wb_valid       = 2'b00;
        #1;
        check_issue("t4_nolost", mk(4'd6, 7'd4, 7'd12, 1'b1, 1'b0));
        check("t4_raddr2", 128'(prf_raddr2), 128'(7'd12));
        tick();
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd7, 7'd4, 7'd13, 1'b1, 1'b0);
        wb_valid       = 2'b11;
        wb_prd[0]      = 7'd14;
        wb_prd[1]      = 7'd15;
        tick();
        dispatch_valid = 1'b0;
        wb_valid       = 2'b10;
        wb_prd[1]      = 7'd13;
        #1;
        check("t4_wrong_tag", 128'(issue_en), 128'(1'b0));
        check("t4_occ1", 128'(occupancy), 128'(3'd1));
        tick();
        wb_valid = 2'b00;
        #1;
        check_issue("t4_port1", mk(4'd7, 7'd4, 7'd13, 1'b1, 1'b0));
        tick();
        check("t4_empty", 128'(occupancy), 128'(3'd0));

        // Flush with three entries and a pending issue drops everything.
        ready          = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd8, 7'd30, 7'd31, 1'b1, 1'b1);
        tick();
        dispatch_entry = mk(4'd9, 7'd20, 7'd31, 1'b0, 1'b1);
        tick();
        dispatch_entry = mk(4'd10, 7'd32, 7'd33, 1'b1, 1'b1);
        tick();
        dispatch_entry = mk(4'd11, 7'd34, 7'd35, 1'b1, 1'b1);
        #1;
        check("t5_occ3", 128'(occupancy), 128'(3'd3));
        check_issue("t5_pending", mk(4'd8, 7'd30, 7'd31, 1'b1, 1'b1));
        flush = 1'b1;
        ready = 1'b1;
        #1;
        check("t5_flush_issue", 128'(issue_en), 128'(1'b0));
        check("t5_flush_rdy", 128'(dispatch_ready), 128'(1'b0));
        tick();
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        #1;
        check("t5_occ0", 128'(occupancy), 128'(3'd0));
        check("t5_idle", 128'(issue_en), 128'(1'b0));
        check("t5_rdy", 128'(dispatch_ready), 128'(1'b1));
        tick();
        check("t5_dropped", 128'(occupancy), 128'(3'd0));

        // Reset in the middle of operation clears held entries.
        ready          = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_entry = mk(4'd12, 7'd50, 7'd51, 1'b1, 1'b1);
        tick();
        dispatch_valid = 1'b0;
        #1;
        check_issue("t6_before", mk(4'd12, 7'd50, 7'd51, 1'b1, 1'b1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t6_occ0", 128'(occupancy), 128'(3'd0));
        check("t6_idle", 128'(issue_en), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
